// File: rtl/mux_out_deser.sv
// -----------------------------------------------------------------------------
// mux_out_deser
// Serial-to-parallel deserializer for the bit stream coming out of the
// upstream mux2. Bits are assembled LSB-first into WIDTH-bit words and handed
// downstream through a one-word output register with a valid/ready handshake.
// When the output register is still occupied, one completed word can be parked
// in the shift register (state FULL) while the input is stalled.
//
// Optional feature macro: DESER_PARITY_EN
//   When defined, parity_out carries the even parity (XOR of all bits) of the
//   word currently held in word_out, registered alongside it.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   bit_in      in   1      serial data bit
//   bit_valid   in   1      bit_in holds a valid bit
//   bit_ready   out  1      block accepts bit_in this cycle
//   word_out    out  WIDTH  assembled word
//   word_valid  out  1      word_out holds a valid word
//   word_ready  in   1      downstream consumes word_out this cycle
//   parity_out  out  1      even parity of word_out (DESER_PARITY_EN only)
// -----------------------------------------------------------------------------
module mux_out_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready
`ifdef DESER_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_count;
  logic             r_wordValid;

  logic             w_bitReady;
  logic             w_bitAcc;
  logic             w_consume;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_assembled;
  logic             w_loadFromBits;
  logic             w_loadFromShift;

  // New bits enter at the MSB and shift right, so after WIDTH accepted bits
  // the first one sits in bit 0.
  assign w_assembled = {bit_in, r_shift[WIDTH-1:1]};
  assign w_lastBit   = (r_count == LAST_COUNT);
  assign w_bitAcc    = bit_valid && w_bitReady;
  assign w_consume   = r_wordValid && word_ready;

  assign bit_ready   = w_bitReady;
  assign word_out    = r_word;
  assign word_valid  = r_wordValid;

  // Next-state and load decisions. A completed word goes straight to the
  // output register if it is empty or being drained on this very edge;
  // otherwise it stays parked in the shift register and input is stalled.
  always_comb begin
    w_nextState     = r_state;
    w_bitReady      = 1'b0;
    w_loadFromBits  = 1'b0;
    w_loadFromShift = 1'b0;
    case (r_state)
      FILL: begin
        w_bitReady = 1'b1;
        if (bit_valid && w_lastBit) begin
          if (!r_wordValid || word_ready) begin
            w_loadFromBits = 1'b1;
          end else begin
            w_nextState = FULL;
          end
        end
      end
      FULL: begin
        if (w_consume) begin
          w_loadFromShift = 1'b1;
          w_nextState     = FILL;
        end
      end
      default: begin
        w_nextState = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Shift register and bit counter only move on an accepted bit, so gaps in
  // bit_valid leave a partial word untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_bitAcc) begin
      r_shift <= w_assembled;
      r_count <= w_lastBit ? '0 : r_count + 1'b1;
    end
  end

  // Output register: a load on the same edge as a consumption keeps
  // word_valid high with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word      <= '0;
      r_wordValid <= 1'b0;
    end else if (w_loadFromBits) begin
      r_word      <= w_assembled;
      r_wordValid <= 1'b1;
    end else if (w_loadFromShift) begin
      r_word      <= r_shift;
      r_wordValid <= 1'b1;
    end else if (w_consume) begin
      r_wordValid <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  logic r_parity;

  // Parity is computed from the word as it loads, so it changes only when
  // word_out changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_loadFromBits) begin
      r_parity <= ^w_assembled;
    end else if (w_loadFromShift) begin
      r_parity <= ^r_shift;
    end
  end

  assign parity_out = r_parity;
`endif

endmodule

// File: tb/tb_mux_out_deser.sv
// -----------------------------------------------------------------------------
// tb_mux_out_deser
// Self-checking bench for mux_out_deser (WIDTH=8). Every bit driven is fed to
// a small bench-side assembler; each completed word is pushed onto a queue and
// popped when the DUT hands a word downstream. Directed checks cover reset,
// latency, back-pressure, throughput, gaps and reset mid-word.
// Build with +define+DESER_PARITY_EN to also check parity_out.
// -----------------------------------------------------------------------------
module tb_mux_out_deser;

  localparam int WIDTH = 8;
  localparam int READY_LIMIT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
`ifdef DESER_PARITY_EN
  logic             parity_out;
`endif

  int checkCount = 0;
  int errorCount = 0;

  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] modelAcc = '0;
  int               modelCnt = 0;
  int               cycleCount = 0;
  int               lastPopCycle = 0;
  int               prevPopCycle = 0;
  int               popCount = 0;
  int               maxWait = 0;

  mux_out_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready)
`ifdef DESER_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between emitted words.
  always @(posedge clk) begin
    cycleCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Handshakes are looked at on the falling edge, half a cycle before the
  // rising edge that completes them.
  always @(negedge clk) begin
    logic [WIDTH-1:0] expWord;
    if (rst === 1'b0 && word_valid === 1'b1 && word_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWord", 32'(word_out), 32'hFFFF_FFFF);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("scoreWord", 32'(word_out), 32'(expWord));
`ifdef DESER_PARITY_EN
        checkOutput("scoreParity", 32'(parity_out), 32'(^expWord));
`endif
      end
      prevPopCycle = lastPopCycle;
      lastPopCycle = cycleCount;
      popCount++;
    end
  end

  task automatic modelPush(input logic b);
    modelAcc = {b, modelAcc[WIDTH-1:1]};
    modelCnt++;
    if (modelCnt == WIDTH) begin
      expQ.push_back(modelAcc);
      modelCnt = 0;
    end
  endtask

  // Present one bit, wait (bounded) for bit_ready, then let one edge accept it.
  // bit_valid is left high so consecutive calls stream back-to-back.
  task automatic applyStimulus(input logic b);
    int waited;
    bit_in    = b;
    bit_valid = 1'b1;
    waited    = 0;
    while (bit_ready !== 1'b1 && waited < READY_LIMIT) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited > maxWait) maxWait = waited;
    if (waited >= READY_LIMIT) begin
      checkOutput("bitReadyTimeout", 32'(bit_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      modelPush(b);
    end
  endtask

  task automatic sendBits(input logic [WIDTH-1:0] w, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      applyStimulus(w[i]);
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    modelCnt = 0;
    modelAcc = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w;
    int popBefore;
    int bad;

    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    @(posedge clk);
    #1;
    applyReset();

    // Reset state
    checkOutput("rstWordValid", 32'(word_valid), 32'd0);
    checkOutput("rstWordOut", 32'(word_out), 32'h00);
    checkOutput("rstBitReady", 32'(bit_ready), 32'd1);
`ifdef DESER_PARITY_EN
    checkOutput("rstParity", 32'(parity_out), 32'd0);
`endif

    // 1,0,1,0,0,1,0,1 LSB-first -> 8'hA5, valid for exactly one cycle
    word_ready = 1'b1;
    sendBits(8'hA5, 0, 8);
    bit_valid = 1'b0;
    checkOutput("a5Valid", 32'(word_valid), 32'd1);
    checkOutput("a5Word", 32'(word_out), 32'hA5);
`ifdef DESER_PARITY_EN
    checkOutput("a5Parity", 32'(parity_out), 32'd0);
`endif
    idle(1);
    checkOutput("a5ValidOneCycle", 32'(word_valid), 32'd0);

    // Back-pressure: 16 bits with word_ready low
    word_ready = 1'b0;
    sendBits(8'h3E, 0, 8);
    sendBits(8'hC1, 0, 8);
    bit_valid = 1'b0;
    checkOutput("fullBitReady", 32'(bit_ready), 32'd0);
    checkOutput("fullWordValid", 32'(word_valid), 32'd1);
    checkOutput("fullWordOut", 32'(word_out), 32'h3E);
    idle(3);
    checkOutput("holdWordOut", 32'(word_out), 32'h3E);
    checkOutput("holdBitReady", 32'(bit_ready), 32'd0);
    word_ready = 1'b1;
    idle(1);
    checkOutput("drainSecondWord", 32'(word_out), 32'hC1);
    checkOutput("drainSecondValid", 32'(word_valid), 32'd1);
    checkOutput("drainBitReady", 32'(bit_ready), 32'd1);
    idle(1);
    checkOutput("drainDoneValid", 32'(word_valid), 32'd0);
    checkOutput("drainConsecutive", 32'(lastPopCycle - prevPopCycle), 32'd1);

    // Sustained throughput with word_ready high
    maxWait   = 0;
    popBefore = popCount;
    for (int k = 0; k < 3; k++) begin
      w = WIDTH'($urandom_range(0, 255));
      sendBits(w, 0, 8);
    end
    bit_valid = 1'b0;
    checkOutput("streamNoStall", 32'(maxWait), 32'd0);
    idle(1);
    checkOutput("streamWordCount", 32'(popCount - popBefore), 32'd3);
    checkOutput("streamSpacing", 32'(lastPopCycle - prevPopCycle), 32'd8);

    // Gap in the middle of a word: 3 bits, 5 idle cycles, 5 bits of 8'h3C
    sendBits(8'h3C, 0, 3);
    idle(5);
    checkOutput("gapNoWord", 32'(word_valid), 32'd0);
    sendBits(8'h3C, 3, 5);
    bit_valid = 1'b0;
    checkOutput("gapValid", 32'(word_valid), 32'd1);
    checkOutput("gapWord", 32'(word_out), 32'h3C);
    idle(1);

    // Reset after 4 bits, then 8'hFF: only 8'hFF is emitted
    sendBits(8'h0D, 0, 4);
    applyReset();
    checkOutput("midRstValid", 32'(word_valid), 32'd0);
    checkOutput("midRstBitReady", 32'(bit_ready), 32'd1);
    popBefore = popCount;
    sendBits(8'hFF, 0, 8);
    bit_valid = 1'b0;
    checkOutput("ffWord", 32'(word_out), 32'hFF);
`ifdef DESER_PARITY_EN
    checkOutput("ffParity", 32'(parity_out), 32'd0);
`endif
    idle(1);
    checkOutput("ffOnlyOne", 32'(popCount - popBefore), 32'd1);

    // word_ready with nothing valid has no effect
    word_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      idle(1);
      if (word_valid !== 1'b0) bad++;
    end
    checkOutput("idleReadyValid", 32'(bad), 32'd0);
    sendBits(8'h96, 0, 7);
    checkOutput("idleReadyCount7", 32'(word_valid), 32'd0);
    sendBits(8'h96, 7, 1);
    bit_valid = 1'b0;
    checkOutput("idleReadyCount8", 32'(word_valid), 32'd1);
    checkOutput("idleReadyWord", 32'(word_out), 32'h96);
    idle(2);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
